// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Pipeline hazard control: decides when to stall, hold or flush the pipeline
// registers for hazards that bypassing cannot cover (load-use, multi-cycle
// MUL/DIV occupancy of EX, and control redirects resolved in EX). Also keeps a
// saturating count of PC-stall cycles.
//
// Ports:
//   clk, rstn          clock (rising edge), synchronous active-low reset
//   IFID_rs1/rs2       source registers of the ID instruction
//   ID_use_rs1/rs2     ID instruction actually reads rs1/rs2
//   IDEX_memread       EX instruction is a load
//   IDEX_regwrite      EX instruction writes rd
//   IDEX_rd            destination of the EX instruction
//   IDEX_md            EX instruction is MUL/DIV
//   EX_redirect        taken branch/jump resolved in EX
//   pc_stall           hold PC
//   IFID_stall/flush   hold / clear IF/ID
//   IDEX_stall/flush   hold / bubble ID/EX
//   EXMEM_flush        bubble EX/MEM
//   md_busy            MUL/DIV sequencer is in its busy state
//   md_done            one-cycle pulse, MUL/DIV result valid
//   stall_cycles       saturating count of cycles with pc_stall=1
module hazard_stall_unit #(
  parameter int unsigned MD_CYCLES = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [4:0]        IFID_rs1,
  input  logic [4:0]        IFID_rs2,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic              IDEX_memread,
  input  logic              IDEX_regwrite,
  input  logic [4:0]        IDEX_rd,
  input  logic              IDEX_md,
  input  logic              EX_redirect,
  output logic              pc_stall,
  output logic              IFID_stall,
  output logic              IFID_flush,
  output logic              IDEX_stall,
  output logic              IDEX_flush,
  output logic              EXMEM_flush,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   perf_q, perf_d;

  logic lu;
  logic md_stall;

  // Load-use: a load in EX feeds a register the ID instruction reads. x0 never
  // counts since it is hard-wired to zero.
  always_comb begin
    lu = IDEX_memread & IDEX_regwrite & (IDEX_rd != 5'd0) &
         ((ID_use_rs1 & (IDEX_rd == IFID_rs1)) |
          (ID_use_rs2 & (IDEX_rd == IFID_rs2)));
  end

  // The stall starts in the IDLE cycle the MUL/DIV reaches EX, so it covers
  // exactly MD_CYCLES cycles; the final BUSY cycle (cnt==0) lets it advance.
  always_comb begin
    md_stall = ((state_q == StIdle) & IDEX_md) |
               ((state_q == StBusy) & (cnt_q != '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (IDEX_md) begin
          state_d = StBusy;
          cnt_d   = CNT_W'(MD_CYCLES - 1);
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StIdle;
          md_done = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // MUL/DIV freeze outranks everything: EX holds its instruction, so nothing
  // behind it may be flushed. A redirect outranks load-use because the ID
  // instruction is on the wrong path and is discarded instead of held.
  always_comb begin
    pc_stall    = md_stall | (lu & ~EX_redirect);
    IFID_stall  = pc_stall;
    IDEX_stall  = md_stall;
    EXMEM_flush = md_stall;
    IDEX_flush  = ~md_stall & (lu | EX_redirect);
    IFID_flush  = ~md_stall & EX_redirect;
    md_busy     = (state_q == StBusy);
  end

  always_comb begin
    perf_d = perf_q;
    if (pc_stall && !(&perf_q)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  assign stall_cycles = perf_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int MD = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, memread, regwrite, md, redirect;

  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush;
  logic        md_busy, md_done;
  logic [31:0] stall_cycles;

  logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_flush;
  logic        s_exmem_flush, s_md_busy, s_md_done;
  logic [3:0]  s_stall_cycles;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MD_CYCLES(MD), .CNT_W(8), .PERF_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .IFID_rs1(rs1), .IFID_rs2(rs2), .ID_use_rs1(use1), .ID_use_rs2(use2),
    .IDEX_memread(memread), .IDEX_regwrite(regwrite), .IDEX_rd(rd),
    .IDEX_md(md), .EX_redirect(redirect),
    .pc_stall(pc_stall), .IFID_stall(ifid_stall), .IFID_flush(ifid_flush),
    .IDEX_stall(idex_stall), .IDEX_flush(idex_flush), .EXMEM_flush(exmem_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  hazard_stall_unit #(.MD_CYCLES(MD), .CNT_W(8), .PERF_W(4)) dut_sat (
    .clk(clk), .rstn(rstn),
    .IFID_rs1(rs1), .IFID_rs2(rs2), .ID_use_rs1(use1), .ID_use_rs2(use2),
    .IDEX_memread(memread), .IDEX_regwrite(regwrite), .IDEX_rd(rd),
    .IDEX_md(md), .EX_redirect(redirect),
    .pc_stall(s_pc_stall), .IFID_stall(s_ifid_stall), .IFID_flush(s_ifid_flush),
    .IDEX_stall(s_idex_stall), .IDEX_flush(s_idex_flush), .EXMEM_flush(s_exmem_flush),
    .md_busy(s_md_busy), .md_done(s_md_done), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: md_age = cycles spent in the MUL/DIV busy phase so far (0 = none).
  int      md_age = 0;
  longint  m_cnt  = 0;
  int      m_cnt4 = 0;

  always @(negedge clk) begin
    bit e_lu, e_mds, e_pcs, e_idexf, e_ifidf, e_busy, e_done;
    e_lu    = memread && regwrite && rd != 0 &&
              ((use1 && rd == rs1) || (use2 && rd == rs2));
    e_mds   = (md_age == 0) ? md : (md_age < MD);
    e_busy  = md_age != 0;
    e_done  = md_age == MD;
    e_pcs   = e_mds || (e_lu && !redirect);
    e_idexf = !e_mds && (e_lu || redirect);
    e_ifidf = !e_mds && redirect;
    if (chk_en) begin
      chk("pc_stall",     32'(pc_stall),    32'(e_pcs));
      chk("IFID_stall",   32'(ifid_stall),  32'(e_pcs));
      chk("IFID_flush",   32'(ifid_flush),  32'(e_ifidf));
      chk("IDEX_stall",   32'(idex_stall),  32'(e_mds));
      chk("IDEX_flush",   32'(idex_flush),  32'(e_idexf));
      chk("EXMEM_flush",  32'(exmem_flush), 32'(e_mds));
      chk("md_busy",      32'(md_busy),     32'(e_busy));
      chk("md_done",      32'(md_done),     32'(e_done));
      chk("stall_cycles", stall_cycles,     32'(m_cnt));
      chk("stall_cycles_sat", 32'(s_stall_cycles), 32'(m_cnt4));
    end
    if (!rstn) begin
      md_age = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (e_pcs) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (md_age == 0) md_age = md ? 1 : 0;
      else if (md_age == MD) md_age = 0;
      else md_age++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0;
    memread = 0; regwrite = 0; md = 0; redirect = 0;
  endtask

  task automatic set_lu();
    memread = 1; regwrite = 1; rd = 5; rs2 = 5; use2 = 1;
  endtask

  // Extra load-use encodings, checked by the model only: {rs1,rs2,rd,use1,use2}.
  typedef struct {logic [4:0] r1; logic [4:0] r2; logic [4:0] d; logic u1; logic u2;} vec_t;
  vec_t vecs[5] = '{
    '{r1: 5'd7, r2: 5'd3, d: 5'd7, u1: 1'b1, u2: 1'b0},
    '{r1: 5'd7, r2: 5'd3, d: 5'd7, u1: 1'b0, u2: 1'b1},
    '{r1: 5'd9, r2: 5'd9, d: 5'd9, u1: 1'b1, u2: 1'b1},
    '{r1: 5'd0, r2: 5'd0, d: 5'd0, u1: 1'b1, u2: 1'b1},
    '{r1: 5'd4, r2: 5'd6, d: 5'd5, u1: 1'b1, u2: 1'b1}
  };

  initial begin
    idle();
    rstn = 0;
    step(); step();
    rstn = 1;
    chk_en = 1;
    #4;
    chk("reset pc_stall", 32'(pc_stall), 32'd0);
    chk("reset stall_cycles", stall_cycles, 32'd0);

    // Load-use through rs2
    step(); set_lu(); #5;
    chk("lu pc_stall", 32'(pc_stall), 32'd1);
    chk("lu IDEX_flush", 32'(idex_flush), 32'd1);
    step(); idle(); #5;
    chk("lu one cycle", 32'(pc_stall), 32'd0);
    chk("lu count", stall_cycles, 32'd1);

    // Load to x0
    step(); set_lu(); rd = 0; rs2 = 0; #5;
    chk("x0 pc_stall", 32'(pc_stall), 32'd0);
    chk("x0 IDEX_flush", 32'(idex_flush), 32'd0);
    step(); idle(); #5;
    chk("x0 count", stall_cycles, 32'd1);

    // Redirect beats load-use
    step(); set_lu(); redirect = 1; #5;
    chk("redir IFID_flush", 32'(ifid_flush), 32'd1);
    chk("redir IDEX_flush", 32'(idex_flush), 32'd1);
    chk("redir pc_stall", 32'(pc_stall), 32'd0);
    step(); idle(); #5;

    // MUL/DIV held from cycle 0 through cycle 8
    for (int c = 0; c < 10; c++) begin
      step(); md = (c < 9); #5;
      chk("md pc_stall", 32'(pc_stall), 32'(c < 8));
      chk("md busy", 32'(md_busy), 32'(c >= 1 && c <= 8));
      chk("md done", 32'(md_done), 32'(c == 8));
    end
    chk("md count", stall_cycles, 32'd9);

    // Redirect and load-use during BUSY are masked
    for (int c = 0; c < 10; c++) begin
      step(); idle(); md = (c < 9);
      if (c == 3) begin set_lu(); redirect = 1; end
      #5;
      if (c == 3) begin
        chk("busy IFID_flush", 32'(ifid_flush), 32'd0);
        chk("busy IDEX_flush", 32'(idex_flush), 32'd0);
        chk("busy IDEX_stall", 32'(idex_stall), 32'd1);
      end
    end
    chk("busy count", stall_cycles, 32'd17);

    // Reset in cycle 3 of a MUL/DIV
    for (int c = 0; c < 6; c++) begin
      step(); idle(); md = (c < 4); rstn = (c != 3);
      if (c == 4) md = 0;
      #5;
      if (c == 4) begin
        chk("rst md_busy", 32'(md_busy), 32'd0);
        chk("rst stall_cycles", stall_cycles, 32'd0);
        chk("rst md_done", 32'(md_done), 32'd0);
      end
    end

    // Continuous load-use stall: narrow counter must stick at all-ones
    step(); idle(); set_lu();
    for (int c = 0; c < 20; c++) step();
    idle(); #5;
    chk("sat value", 32'(s_stall_cycles), 32'd15);
    chk("wide count", stall_cycles, 32'd20);

    for (int i = 0; i < 5; i++) begin
      step(); idle();
      memread = 1; regwrite = 1;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2; rd = vecs[i].d;
      use1 = vecs[i].u1; use2 = vecs[i].u2;
    end
    step(); idle();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline control block that decides when to stall, hold or flush pipeline registers.
- Covers the hazards that operand bypassing cannot resolve:
  - load-use dependencies;
  - multi-cycle MUL/DIV occupancy of EX;
  - control redirects resolved in EX.
- Sits beside the forwarding unit. Drives the PC, IF/ID, ID/EX and EX/MEM register enables and flushes.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_CYCLES, 8, total EX stall cycles for one MUL/DIV instruction (legal range 2..255).
- CNT_W, 8, width of the internal MUL/DIV down-counter.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  synchronous reset, active low
- IFID_rs1  input  5  rs1 field of the instruction in ID
- IFID_rs2  input  5  rs2 field of the instruction in ID
- ID_use_rs1  input  1  ID instruction reads rs1
- ID_use_rs2  input  1  ID instruction reads rs2
- IDEX_memread  input  1  EX instruction is a load
- IDEX_regwrite  input  1  EX instruction writes rd
- IDEX_rd  input  5  rd of the EX instruction
- IDEX_md  input  1  EX instruction is MUL/DIV
- EX_redirect  input  1  taken branch or jump resolved in EX
- pc_stall  output  1  hold PC
- IFID_stall  output  1  hold IF/ID register
- IFID_flush  output  1  clear IF/ID to a NOP
- IDEX_stall  output  1  hold ID/EX register
- IDEX_flush  output  1  load a bubble into ID/EX
- EXMEM_flush  output  1  load a bubble into EX/MEM
- md_busy  output  1  FSM is in BUSY
- md_done  output  1  one-cycle pulse: MUL/DIV result valid this cycle
- stall_cycles  output  PERF_W  count of cycles with pc_stall=1

Behaviour:
- Clock and reset: one clock domain. rstn is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset: state=IDLE, cnt=0, stall_cycles=0. Outputs are combinational from state, cnt and the inputs. With idle inputs after reset, every output is 0.
- Reset mid-operation (rstn low during BUSY): state returns to IDLE and cnt to 0 on that edge. There is no md_done pulse.
- Load-use term lu: IDEX_memread & IDEX_regwrite & (IDEX_rd!=0) & ((ID_use_rs1 & IDEX_rd==IFID_rs1) | (ID_use_rs2 & IDEX_rd==IFID_rs2)).
- FSM states: IDLE, BUSY.
  - IDLE with IDEX_md=1: go to BUSY, cnt<=MD_CYCLES-1.
  - BUSY with cnt!=0: cnt<=cnt-1, stay in BUSY.
  - BUSY with cnt==0: go to IDLE, md_done=1.
- Stall term mdstall = (IDLE & IDEX_md) | (BUSY & cnt!=0).
  - mdstall is high for exactly MD_CYCLES consecutive cycles.
  - md_done fires on the following cycle, which has no stall, so the MUL/DIV instruction advances on that edge.
- Output equations:
  - pc_stall = IFID_stall = mdstall | (lu & ~EX_redirect)
  - IDEX_stall = EXMEM_flush = mdstall
  - IDEX_flush = ~mdstall & (lu | EX_redirect)
  - IFID_flush = ~mdstall & EX_redirect
  - md_busy = (state==BUSY)
- Priority rules:
  - mdstall beats both redirect and load-use. EX is frozen, so no flush of ID/EX or IF/ID may occur.
  - EX_redirect beats lu. The ID instruction is on the wrong path, so it is flushed rather than stalled.
- rd==0 never causes a load-use stall. Both sources matching counts as one stall.
- Load-use stalls last exactly one cycle per occurrence. After the bubble, IDEX_memread is 0, so lu drops without extra state.
- stall_cycles increments on each edge where pc_stall=1 and rstn=1. It saturates at all-ones and does not wrap.
- No latches. Every output is driven in every state.

Test Plan:
1. Load-use: IDEX_memread=1, IDEX_regwrite=1, IDEX_rd=5, IFID_rs2=5, ID_use_rs2=1 for one cycle -> pc_stall=IFID_stall=IDEX_flush=1 that cycle only; stall_cycles goes 0->1.
2. Load to x0: same as 1 but IDEX_rd=0 -> all control outputs 0; stall_cycles unchanged.
3. Redirect plus load-use in the same cycle (EX_redirect=1 with the lu condition of 1) -> IFID_flush=IDEX_flush=1, pc_stall=0.
4. MUL/DIV with MD_CYCLES=8: IDEX_md=1 held from cycle 0 ->
   - IDEX_stall=EXMEM_flush=pc_stall=1 for cycles 0-7;
   - md_busy=1 for cycles 1-8;
   - md_done=1 only in cycle 8; IDLE in cycle 9;
   - stall_cycles=8.
5. EX_redirect=1 and lu asserted during BUSY -> IFID_flush=0, IDEX_flush=0; stall outputs unchanged.
6. Reset mid-MD: rstn=0 in cycle 3 of test 4 -> cycle 4 has state IDLE, md_busy=0, stall_cycles=0, and md_done is never asserted. Separately, force stall_cycles to all-ones, then stall one more cycle -> value stays all-ones.
